// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: FSM state encoding, endpoint addresses and bus width.
// Used by the OUT reader, the IN writer and the bus arbiter.
package fx2_pkg;

  localparam int unsigned FD_W = 16;

  localparam logic [1:0] FX2_EP2       = 2'b00;
  localparam logic [1:0] FX2_EP6       = 2'b10;
  localparam logic [1:0] FX2_ADDR_IDLE = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_OE,
    ST_READ,
    ST_END
  } fx2_state_e;

endpackage

// File: rtl/fx2_ep_out_reader_if.sv
// FX2 OUT-endpoint bus plus the downstream valid/ready stream of the reader.
// master = the reader; slave = FX2/arbiter/consumer side.
interface fx2_ep_out_reader_if;
  import fx2_pkg::*;

  logic [FD_W-1:0] fd_i;
  logic            flaga;
  logic [1:0]      fifoadr;
  logic            sloe_n;
  logic            slrd_n_c;
  logic            bus_req;
  logic            bus_gnt;
  logic [FD_W-1:0] rd_data;
  logic            rd_valid;
  logic            rd_ready;

  modport master (
    input  fd_i, flaga, bus_gnt, rd_ready,
    output fifoadr, sloe_n, slrd_n_c, bus_req, rd_data, rd_valid
  );

  modport slave (
    output fd_i, flaga, bus_gnt, rd_ready,
    input  fifoadr, sloe_n, slrd_n_c, bus_req, rd_data, rd_valid
  );

endinterface

// File: rtl/fx2_sync_fifo.sv
// Single-clock circular buffer; pointers carry one extra bit so full/empty are told apart by the MSB.
module fx2_sync_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_free
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  assign w_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                   (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
  assign o_free  = (DEPTH_LOG2+1)'(DEPTH) - w_count;

  // A pop on the same edge frees the slot, so push on full is allowed then.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!w_full || w_pop);

  // Head word is forced to zero while empty so the output has a defined reset value.
  assign o_data = o_empty ? '0 : r_mem[r_rptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (DEPTH_LOG2+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (DEPTH_LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/fx2_ep_out_reader.sv
// FX2 synchronous slave-FIFO OUT endpoint reader: bursts FD words into a local buffer per bus grant.
// Optional FX2_RD_CNT_EN adds o_rd_count, a wrapping total of captured words.
module fx2_ep_out_reader
  import fx2_pkg::*;
#(
  parameter logic [1:0]  EP_ADDR    = FX2_EP2,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned BURST_MAX  = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  fx2_ep_out_reader_if.master bus
`ifdef FX2_RD_CNT_EN
  ,
  output logic [31:0]         o_rd_count
`endif
);

  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

  fx2_state_e          r_state;
  fx2_state_e          w_state_nxt;
  logic [BURST_W-1:0]  r_burst;
  logic                r_bus_req;
  logic [1:0]          r_fifoadr;
  logic                r_sloe_n;
  logic                w_slrd_n;
  logic                w_capture;
  logic                w_room;
  logic                w_burst_ok;
  logic                w_empty;
  logic                w_pop;
  logic [FD_W-1:0]     w_head;
  logic [DEPTH_LOG2:0] w_free;

  // Two free slots keep a margin so the buffer cannot overflow behind the read strobe.
  assign w_room     = (w_free >= (DEPTH_LOG2+1)'(2));
  assign w_burst_ok = (r_burst < BURST_W'(BURST_MAX));
  assign w_capture  = !w_slrd_n && bus.flaga;
  assign w_pop      = bus.rd_ready && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_slrd_n    = 1'b1;
    case (r_state)
      ST_IDLE: if (bus.flaga && w_room) w_state_nxt = ST_REQ;
      ST_REQ:  if (bus.bus_gnt) w_state_nxt = ST_ADDR;
      ST_ADDR: w_state_nxt = ST_OE;
      ST_OE:   w_state_nxt = ST_READ;
      ST_READ: begin
        // Low buffer room only pauses the strobe; the bus stays owned with SLOE asserted.
        if (bus.flaga && w_room && w_burst_ok && bus.bus_gnt) w_slrd_n = 1'b0;
        if (!bus.flaga || !w_burst_ok || !bus.bus_gnt) w_state_nxt = ST_END;
      end
      ST_END:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bus controls are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_bus_req <= 1'b0;
      r_fifoadr <= FX2_ADDR_IDLE;
      r_sloe_n  <= 1'b1;
      r_burst   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bus_req <= (w_state_nxt inside {ST_REQ, ST_ADDR, ST_OE, ST_READ});
      r_fifoadr <= (w_state_nxt inside {ST_ADDR, ST_OE, ST_READ}) ? EP_ADDR : FX2_ADDR_IDLE;
      r_sloe_n  <= !(w_state_nxt inside {ST_OE, ST_READ});
      if (r_state == ST_END)  r_burst <= '0;
      else if (w_capture)     r_burst <= r_burst + BURST_W'(1);
    end
  end

  fx2_sync_fifo #(
    .WIDTH      (FD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_capture),
    .i_data  (bus.fd_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_free  (w_free)
  );

  assign bus.bus_req  = r_bus_req;
  assign bus.fifoadr  = r_fifoadr;
  assign bus.sloe_n   = r_sloe_n;
  assign bus.slrd_n_c = w_slrd_n;
  assign bus.rd_data  = w_head;
  assign bus.rd_valid = !w_empty;

`ifdef FX2_RD_CNT_EN
  logic [31:0] r_rd_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_rd_count <= '0;
    else if (w_capture) r_rd_count <= r_rd_count + 32'd1;
  end

  assign o_rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fx2_ep_out_reader.sv
// Directed bench for fx2_ep_out_reader with a queue model of the FX2 OUT FIFO.
// Define FX2_RD_CNT_EN to also check o_rd_count.
module tb_fx2_ep_out_reader;
  import fx2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  fx2_ep_out_reader_if bus();
`ifdef FX2_RD_CNT_EN
  logic [31:0] rd_count;
`endif

  logic [15:0] fx_mem [0:1023];
  int          fx_rd = 0;
  int          fx_wr = 0;
  int          n_cap = 0;
  logic [15:0] got [$];

  always #5 clk = ~clk;

  fx2_ep_out_reader #(
    .EP_ADDR    (FX2_EP6),
    .DEPTH_LOG2 (4),
    .BURST_MAX  (8)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus)
`ifdef FX2_RD_CNT_EN
    ,
    .o_rd_count (rd_count)
`endif
  );

  // FX2 OUT FIFO model: FLAGA while words remain, one word popped per strobed edge.
  assign bus.flaga = (fx_rd < fx_wr);
  assign bus.fd_i  = fx_mem[fx_rd[9:0]];

  always @(posedge clk) begin
    if (!bus.slrd_n_c && bus.flaga) begin
      fx_rd <= fx_rd + 1;
      n_cap <= n_cap + 1;
    end
    if (bus.rd_valid && bus.rd_ready) got.push_back(bus.rd_data);
  end

  function automatic logic [4:0] ctrl_bits();
    return {bus.bus_req, bus.fifoadr, bus.sloe_n, bus.slrd_n_c};
  endfunction

  function automatic logic [15:0] got_at(input int idx);
    if (idx < got.size()) return got[idx];
    return 16'hxxxx;
  endfunction

  task automatic push_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) fx_mem[fx_wr + i] = base + 16'(i);
    fx_wr = fx_wr + n;
  endtask

  task automatic drain(input int target, output bit done);
    done = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (got.size() >= target && fx_rd == fx_wr && !bus.rd_valid && !bus.bus_req) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.bus_gnt  = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_bits() !== 5'b00011) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00011", ctrl_bits());
    end
    n_checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_stream: got valid=%b data=%h expected 0/0000", bus.rd_valid, bus.rd_data);
    end
`ifdef FX2_RD_CNT_EN
    n_checks++;
    if (rd_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", rd_count);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctrl_bits() !== 5'b00011) begin
      n_fail++; $display("FAIL reset_idle: got %b expected 00011", ctrl_bits());
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp_c [10] = '{5'b10011, 5'b11011, 5'b11001, 5'b11000, 5'b11000,
                               5'b11000, 5'b11000, 5'b11001, 5'b00011, 5'b00011};
    int g0 = got.size();
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    push_words(4, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctrl_bits() !== exp_c[i]) begin
        n_fail++; $display("FAIL basic_ctrl[%0d]: got %b expected %b", i, ctrl_bits(), exp_c[i]);
      end
      if (i == 4) begin
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h0001) begin
          n_fail++; $display("FAIL basic_latency: got valid=%b data=%h expected 1/0001", bus.rd_valid, bus.rd_data);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (got.size() !== g0 + 4) begin
      n_fail++; $display("FAIL basic_count: got %0d expected %0d", got.size() - g0, 4);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'(k + 1)) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'(k + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    int g0 = got.size();
    int c0 = n_cap;
    bit done;
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    push_words(20, 16'h0200);
    repeat (50) @(negedge clk);
    n_checks++;
    if (n_cap - c0 !== 15) begin
      n_fail++; $display("FAIL bp_fill: got %0d words expected 15", n_cap - c0);
    end
    n_checks++;
    if (ctrl_bits() !== 5'b11001) begin
      n_fail++; $display("FAIL bp_pause_ctrl: got %b expected 11001", ctrl_bits());
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_cap - c0 !== 15 || bus.rd_data !== 16'h0200) begin
      n_fail++; $display("FAIL bp_hold: got %0d words head=%h expected 15 head=0200", n_cap - c0, bus.rd_data);
    end
    bus.rd_ready = 1'b1;
    drain(g0 + 20, done);
    n_checks++;
    if (!done || got.size() !== g0 + 20 || n_cap - c0 !== 20) begin
      n_fail++; $display("FAIL bp_resume: got done=%b out=%0d cap=%0d expected 1/20/20", done, got.size() - g0, n_cap - c0);
    end
    for (int k = 0; k < 20; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'h0200 + 16'(k)) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'h0200 + 16'(k));
      end
    end
  endtask

  task automatic test_burst_limit();
    int g0 = got.size();
    int c0 = n_cap;
    int lo = 0;
    int t = 0;
    bit done;
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    push_words(12, 16'h0300);
    while (bus.bus_req !== 1'b1 && t < 10) begin @(negedge clk); t++; end
    while (bus.bus_req === 1'b1 && t < 40) begin
      if (bus.slrd_n_c === 1'b0) lo++;
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (lo !== 8) begin
      n_fail++; $display("FAIL burst_reads: got %0d expected 8", lo);
    end
    n_checks++;
    if (ctrl_bits() !== 5'b00011) begin
      n_fail++; $display("FAIL burst_end_ctrl: got %b expected 00011", ctrl_bits());
    end
    t = 0;
    while (bus.bus_req !== 1'b1 && t < 6) begin @(negedge clk); t++; end
    n_checks++;
    if (bus.bus_req !== 1'b1) begin
      n_fail++; $display("FAIL burst_rereq: got bus_req=%b expected 1", bus.bus_req);
    end
    drain(g0 + 12, done);
    n_checks++;
    if (!done || got.size() !== g0 + 12 || n_cap - c0 !== 12) begin
      n_fail++; $display("FAIL burst_total: got done=%b out=%0d cap=%0d expected 1/12/12", done, got.size() - g0, n_cap - c0);
    end
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'h0300 + 16'(k)) begin
        n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'h0300 + 16'(k));
      end
    end
  endtask

  task automatic test_abort();
    int g0 = got.size();
    int c_ab;
    int t = 0;
    bit done;
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    push_words(10, 16'h0400);
    while (bus.slrd_n_c !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    bus.bus_gnt = 1'b0;
    #1;
    n_checks++;
    if (bus.slrd_n_c !== 1'b1) begin
      n_fail++; $display("FAIL abort_slrd: got %b expected 1", bus.slrd_n_c);
    end
    c_ab = n_cap;
    @(negedge clk);
    n_checks++;
    if (ctrl_bits() !== 5'b00011 || n_cap !== c_ab) begin
      n_fail++; $display("FAIL abort_end: got ctrl=%b caps=%0d expected 00011 caps=%0d", ctrl_bits(), n_cap, c_ab);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (ctrl_bits() !== 5'b10011) begin
      n_fail++; $display("FAIL abort_wait_gnt: got %b expected 10011", ctrl_bits());
    end
    bus.bus_gnt = 1'b1;
    drain(g0 + 10, done);
    n_checks++;
    if (!done || got.size() !== g0 + 10) begin
      n_fail++; $display("FAIL abort_total: got done=%b out=%0d expected 1/10", done, got.size() - g0);
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'h0400 + 16'(k)) begin
        n_fail++; $display("FAIL abort_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'h0400 + 16'(k));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int g0 = got.size();
    int s5 = fx_wr;
    int t = 0;
    bit done;
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    push_words(6, 16'h0500);
    while (bus.slrd_n_c !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    n_checks++;
    if (bus.rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_valid: got %b expected 1", bus.rd_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ctrl_bits() !== 5'b00011 || bus.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got ctrl=%b valid=%b expected 00011/0", ctrl_bits(), bus.rd_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctrl_bits() !== 5'b00011) begin
      n_fail++; $display("FAIL rst_release: got %b expected 00011", ctrl_bits());
    end
    n_checks++;
    if (fx_rd - s5 !== 1) begin
      n_fail++; $display("FAIL rst_pre_caps: got %0d expected 1", fx_rd - s5);
    end
    @(negedge clk);
    n_checks++;
    if (ctrl_bits() !== 5'b10011) begin
      n_fail++; $display("FAIL rst_idle_to_req: got %b expected 10011", ctrl_bits());
    end
    bus.rd_ready = 1'b1;
    drain(g0 + 5, done);
    n_checks++;
    if (!done || got.size() !== g0 + 5) begin
      n_fail++; $display("FAIL rst_total: got done=%b out=%0d expected 1/5", done, got.size() - g0);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'h0501 + 16'(k)) begin
        n_fail++; $display("FAIL rst_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'h0501 + 16'(k));
      end
    end
  endtask

  task automatic test_long_stream();
    int g0;
    int c0;
    bit done;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    g0 = got.size();
    c0 = n_cap;
`ifdef FX2_RD_CNT_EN
    n_checks++;
    if (rd_count !== 32'd0) begin
      n_fail++; $display("FAIL long_count_reset: got %0d expected 0", rd_count);
    end
`endif
    bus.bus_gnt  = 1'b1;
    bus.rd_ready = 1'b1;
    push_words(300, 16'h1000);
    drain(g0 + 300, done);
    n_checks++;
    if (!done || got.size() !== g0 + 300 || n_cap - c0 !== 300) begin
      n_fail++; $display("FAIL long_total: got done=%b out=%0d cap=%0d expected 1/300/300", done, got.size() - g0, n_cap - c0);
    end
    for (int k = 0; k < 300; k++) begin
      n_checks++;
      if (got_at(g0 + k) !== 16'h1000 + 16'(k)) begin
        n_fail++; $display("FAIL long_data[%0d]: got %h expected %h", k, got_at(g0 + k), 16'h1000 + 16'(k));
      end
    end
`ifdef FX2_RD_CNT_EN
    n_checks++;
    if (rd_count !== 32'd300) begin
      n_fail++; $display("FAIL long_count: got %0d expected 300", rd_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_burst_limit();
    test_abort();
    test_reset_mid_read();
    test_long_stream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
